alu_multicycle: RTL and testbench

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

---
 rtl/alu_multicycle.sv | 171 +++++++++++++++++
 tb/tb_alu_multicycle.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle logic/arithmetic ops, WIDTH-step iterative
// MUL (shift-add) and DIV (restoring), valid/ready handshake on both sides.
// Optional signed-overflow flag is built only when ALU_MULTICYCLE_OVERFLOW_EN
// is defined; otherwise v is tied low.
module alu_multicycle #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             c,
    output logic             z,
    output logic             n,
    output logic             dz,
    output logic             v
);

    // state | meaning
    // IDLE  | no result held, ready for a new operation
    // BUSY  | MUL/DIV iterating, one step per cycle
    // DONE  | result and flags presented on out_valid
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [2:0] OP_NOT = 3'b000, OP_OR  = 3'b001, OP_AND = 3'b010,
                           OP_NEG = 3'b011, OP_ADD = 3'b100, OP_SUB = 3'b101,
                           OP_MUL = 3'b110, OP_DIV = 3'b111;
    localparam int CW = $clog2(WIDTH);

    state_t             state, state_nxt;
    logic               accept, iter_start, last_step;
    logic [2*WIDTH-1:0] acc, acc_nxt, mul_nxt, div_nxt;
    logic [WIDTH-1:0]   opnd, mul_add;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [CW-1:0]      cnt;
    logic               is_mul;
    logic [WIDTH-1:0]   q_out;
    logic               q_c, q_dz;

    // DIV by zero short-circuits to a single-cycle result
    assign iter_start = (sel == OP_MUL) || ((sel == OP_DIV) && (b != '0));
    assign last_step  = (state == BUSY) && (cnt == '0);
    assign out_valid  = (state == DONE);

    // Handshake and next-state selection
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            IDLE:    in_ready = rst_n;
            DONE:    in_ready = rst_n & out_ready;
            default: in_ready = 1'b0;
        endcase
        accept = in_valid & in_ready;
        case (state)
            IDLE: begin
                if (accept) state_nxt = iter_start ? BUSY : DONE;
            end
            BUSY: begin
                if (cnt == '0) state_nxt = DONE;
            end
            DONE: begin
                if (accept)         state_nxt = iter_start ? BUSY : DONE;
                else if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Single-cycle result from the live operands at acceptance
    always_comb begin
        q_out = '0;
        q_c   = 1'b0;
        q_dz  = 1'b0;
        case (sel)
            OP_NOT: q_out = ~a;
            OP_OR:  q_out = a | b;
            OP_AND: q_out = a & b;
            OP_NEG: q_out = '0 - a;
            OP_ADD: {q_c, q_out} = {1'b0, a} + {1'b0, b};
            OP_SUB: {q_c, q_out} = {1'b0, a} - {1'b0, b};
            OP_DIV: q_dz = 1'b1;
            default: q_out = '0;
        endcase
    end

    // One iteration step: acc holds {high, low} product or {remainder, quotient}
    always_comb begin
        mul_add   = acc[0] ? opnd : {WIDTH{1'b0}};
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};
        mul_nxt   = {mul_sum, acc[WIDTH-1:1]};
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        div_nxt   = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};
        acc_nxt   = is_mul ? mul_nxt : div_nxt;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Operand capture, iteration and result/flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            opnd   <= '0;
            cnt    <= '0;
            is_mul <= 1'b0;
            out    <= '0;
            c      <= 1'b0;
            z      <= 1'b0;
            n      <= 1'b0;
            dz     <= 1'b0;
        end else if (accept) begin
            if (iter_start) begin
                is_mul <= (sel == OP_MUL);
                acc    <= {{WIDTH{1'b0}}, (sel == OP_MUL) ? b : a};
                opnd   <= (sel == OP_MUL) ? a : b;
                cnt    <= CW'(WIDTH - 1);
            end else begin
                out <= q_out;
                c   <= q_c;
                z   <= (q_out == '0);
                n   <= q_out[WIDTH-1];
                dz  <= q_dz;
            end
        end else if (state == BUSY) begin
            acc <= acc_nxt;
            cnt <= cnt - CW'(1);
            if (cnt == '0) begin
                out <= acc_nxt[WIDTH-1:0];
                c   <= is_mul && (acc_nxt[2*WIDTH-1:WIDTH] != '0);
                z   <= (acc_nxt[WIDTH-1:0] == '0);
                n   <= acc_nxt[WIDTH-1];
                dz  <= 1'b0;
            end
        end
    end

`ifdef ALU_MULTICYCLE_OVERFLOW_EN
    logic q_v;

    // Two's-complement overflow for ADD/SUB only
    always_comb begin
        q_v = 1'b0;
        if (sel == OP_ADD)
            q_v = (a[WIDTH-1] == b[WIDTH-1]) && (q_out[WIDTH-1] != a[WIDTH-1]);
        else if (sel == OP_SUB)
            q_v = (a[WIDTH-1] != b[WIDTH-1]) && (q_out[WIDTH-1] != a[WIDTH-1]);
    end

    // Overflow flag register, cleared for iterative results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       v <= 1'b0;
        else if (accept && !iter_start)   v <= q_v;
        else if (last_step)               v <= 1'b0;
    end
`else
    assign v = 1'b0;
`endif

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle (WIDTH=32): directed vector table,
// randomized ops against an arithmetic reference model, hold/back-to-back
// and reset-during-MUL sequences.
module tb_alu_multicycle;

    logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, out;
    logic [2:0]  sel;
    logic        c, z, n, dz, v;

    int total = 0;
    int bad   = 0;

`ifdef ALU_MULTICYCLE_OVERFLOW_EN
    localparam bit OV = 1'b1;
`else
    localparam bit OV = 1'b0;
`endif

    alu_multicycle #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .c(c), .z(z), .n(n), .dz(dz), .v(v)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  sel;
        logic [31:0] eo;
        logic        ec, ez, en, edz, eov;
        int          lat;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference model in plain integer arithmetic
    function automatic void model(input logic [31:0] ma, input logic [31:0] mb,
                                  input logic [2:0] ms, output logic [31:0] mo,
                                  output logic mc, output logic mdz,
                                  output logic mov, output int lat);
        logic [63:0] wide;
        longint      sr;
        mo = 32'd0; mc = 1'b0; mdz = 1'b0; mov = 1'b0; lat = 1;
        case (ms)
            3'd0: mo = ~ma;
            3'd1: mo = ma | mb;
            3'd2: mo = ma & mb;
            3'd3: begin wide = 64'd0 - {32'd0, ma}; mo = wide[31:0]; end
            3'd4: begin
                wide = {32'd0, ma} + {32'd0, mb};
                mo = wide[31:0]; mc = wide[32];
                sr = longint'(signed'(ma)) + longint'(signed'(mb));
                mov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            3'd5: begin
                mo = ma - mb; mc = (ma < mb);
                sr = longint'(signed'(ma)) - longint'(signed'(mb));
                mov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            3'd6: begin
                wide = {32'd0, ma} * {32'd0, mb};
                mo = wide[31:0]; mc = (wide[63:32] != 32'd0); lat = 33;
            end
            default: begin
                if (mb == 32'd0) begin mo = 32'd0; mdz = 1'b1; end
                else begin mo = ma / mb; lat = 33; end
            end
        endcase
        mov = mov & OV;
    endfunction

    // Issue one op (called at a negedge), scramble inputs after acceptance,
    // then check latency, result, flags, busy in_ready and retire.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_, input logic [2:0] ts,
                          input logic [31:0] eo, input logic ec, input logic ez, input logic en,
                          input logic edz, input logic eov, input int elat, input string tag);
        int k;
        bit busy_ok;
        a = ta; b = tb_; sel = ts; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk({tag, " in_ready"}, in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; a = $urandom; b = $urandom; sel = 3'($urandom);
        k = 0; busy_ok = 1'b1;
        while (k < 100) begin
            @(negedge clk);
            k++;
            if (out_valid) break;
            if (in_ready) busy_ok = 1'b0;
        end
        chk({tag, " latency"}, k, elat);
        chk({tag, " busy_in_ready_low"}, busy_ok, 1'b1);
        chk({tag, " out"}, out, eo);
        chk({tag, " flags_czndv"}, {c, z, n, dz, v}, {ec, ez, en, edz, eov & OV});
        @(posedge clk);
        @(negedge clk);
        chk({tag, " retired"}, {out_valid, out}, {1'b0, eo});
    endtask

    initial begin
        logic [31:0] ra, rb, mo;
        logic [2:0]  rs;
        logic        mc, mdz, mov;
        int          lat;
        bit          late;

        vecs[0]  = '{32'hFFFF_FFFF, 32'h1,       3'd4, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        vecs[1]  = '{32'h3,         32'h5,       3'd5, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        vecs[2]  = '{32'h1_0000,    32'h1_0000,  3'd6, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 33};
        vecs[3]  = '{32'd100,       32'd7,       3'd7, 32'd14,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 33};
        vecs[4]  = '{32'd5,         32'd0,       3'd7, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1};
        vecs[5]  = '{32'h0,         32'h1234,    3'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        vecs[6]  = '{32'h1,         32'h0,       3'd3, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        vecs[7]  = '{32'hF0,        32'h0F,      3'd1, 32'hFF,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        vecs[8]  = '{32'hF0,        32'h0F,      3'd2, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        vecs[9]  = '{32'h7FFF_FFFF, 32'h1,       3'd4, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1};
        vecs[10] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd6, 32'h1,       1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 33};
        vecs[11] = '{32'hFFFF_FFFF, 32'h1,       3'd7, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 33};
        vecs[12] = '{32'd3,         32'd5,       3'd7, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 33};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sel = '0;
        #3;
        chk("reset_state", {out_valid, in_ready, out, c, z, n, dz, v}, 39'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 13; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].eo, vecs[i].ec, vecs[i].ez,
                   vecs[i].en, vecs[i].edz, vecs[i].eov, vecs[i].lat, $sformatf("vec%0d", i));

        for (int i = 0; i < 60; i++) begin
            rs = 3'($urandom);
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            if (rs == 3'd7 && $urandom_range(0, 3) == 0) rb = 32'd0;
            model(ra, rb, rs, mo, mc, mdz, mov, lat);
            run_op(ra, rb, rs, mo, mc, (mo == 32'd0), mo[31], mdz, mov, lat,
                   $sformatf("rnd%0d", i));
        end

        // Hold OR result with out_ready low, then back-to-back AND
        a = 32'h1234_0000; b = 32'h0000_5678; sel = 3'd1; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0; a = $urandom; b = $urandom;
        late = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!(out_valid && !in_ready && out == 32'h1234_5678 && {c, z, n, dz, v} == 5'd0))
                late = 1'b0;
        end
        chk("hold_stable", late, 1'b1);
        a = 32'hFF00_FF00; b = 32'h0FF0_0FF0; sel = 3'd2; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("b2b in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; a = $urandom; b = $urandom;
        @(negedge clk);
        chk("b2b result", {out_valid, out}, {1'b1, 32'h0F00_0F00});
        @(posedge clk);
        @(negedge clk);
        chk("b2b retire", out_valid, 1'b0);

        // Reset in the middle of a MUL
        a = 32'h1_0000; b = 32'h1_0000; sel = 3'd6; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_reset outputs", {out_valid, in_ready, out, c, z, n, dz, v}, 39'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        late = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) late = 1'b1;
        end
        chk("no_late_result", late, 1'b0);
        run_op(32'd100, 32'd7, 3'd7, 32'd14, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 33, "post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
